vga_timing_gen: RTL and testbench

- Horizontal/vertical pixel counter for the VGA controller. It is the stage directly upstream of the comparator block.
- Produces the free-running hcnt/vcnt that the comparator compares against sync/porch/active thresholds.
- Also derives hsync_n, vsync_n, blank_n, frame/line strobes and active-area pixel coordinates for the pixel fetch logic.
- Line layout starts at sync: sync, back porch, active, front porch.

---
 rtl/vga_timing_gen.sv | 153 +++++++++++++++
 tb/tb_vga_timing_gen.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: free-running horizontal/vertical pixel counters for the VGA
// controller, with combinational sync, blanking, coordinate and strobe decode.
// A line runs sync, back porch, active, front porch, so hcnt==0 is the first
// sync pixel. Only hcnt and vcnt are stored; every other output decodes them
// directly and is cycle-aligned with them.
//
// Optional build macro: VGA_FRAME_CNT_EN
//   Defined   -> adds an 8-bit frame_cnt output that increments on each frame
//                wrap and rolls over 255 -> 0.
//   Undefined -> no frame_cnt port or register.
module vga_timing_gen #(
    parameter int N       = 10,
    parameter int HSYN    = 96,
    parameter int HBP     = 48,
    parameter int HACTIVE = 640,
    parameter int HFP     = 16,
    parameter int VSYN    = 2,
    parameter int VBP     = 33,
    parameter int VACTIVE = 480,
    parameter int VFP     = 10
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         pix_en,
`ifdef VGA_FRAME_CNT_EN
    output logic [7:0]   frame_cnt,
`endif
    output logic [N-1:0] hcnt,
    output logic [N-1:0] vcnt,
    output logic         hsync_n,
    output logic         vsync_n,
    output logic         blank_n,
    output logic [N-1:0] x,
    output logic [N-1:0] y,
    output logic         line_end,
    output logic         frame_start
);

    localparam int HMAX = HSYN + HBP + HACTIVE + HFP;
    localparam int VMAX = VSYN + VBP + VACTIVE + VFP;

    localparam int H_ACT_START = HSYN + HBP;
    localparam int H_ACT_END   = HSYN + HBP + HACTIVE;
    localparam int V_ACT_START = VSYN + VBP;
    localparam int V_ACT_END   = VSYN + VBP + VACTIVE;

    // Active-area end bounds can equal 2**N when the front porch is zero, so
    // the upper-bound compares carry one extra bit to avoid truncating to 0.
    localparam logic [N-1:0] HMAX_M1_C     = N'(HMAX - 1);
    localparam logic [N-1:0] VMAX_M1_C     = N'(VMAX - 1);
    localparam logic [N-1:0] HSYN_C        = N'(HSYN);
    localparam logic [N-1:0] VSYN_C        = N'(VSYN);
    localparam logic [N-1:0] H_ACT_START_C = N'(H_ACT_START);
    localparam logic [N-1:0] V_ACT_START_C = N'(V_ACT_START);
    localparam logic [N:0]   H_ACT_END_C   = (N+1)'(H_ACT_END);
    localparam logic [N:0]   V_ACT_END_C   = (N+1)'(V_ACT_END);

    // Counter width must cover both full periods.
    if (HMAX > 2**N) begin : g_hmax_too_wide
        $error("vga_timing_gen: HMAX exceeds counter range 2**N");
    end
    if (VMAX > 2**N) begin : g_vmax_too_wide
        $error("vga_timing_gen: VMAX exceeds counter range 2**N");
    end

    logic [N-1:0] hcnt_q, hcnt_d;
    logic [N-1:0] vcnt_q, vcnt_d;
    logic         h_last;
    logic         v_last;
    logic         h_active;
    logic         v_active;
    logic         active;

    assign h_last = (hcnt_q == HMAX_M1_C);
    assign v_last = (vcnt_q == VMAX_M1_C);

    // Next-count: advance only on pixel-enable; the vertical count steps when
    // the horizontal count wraps, and both wrap together at the frame end.
    always_comb begin
        hcnt_d = hcnt_q;
        vcnt_d = vcnt_q;
        if (pix_en) begin
            if (h_last) begin
                hcnt_d = '0;
                vcnt_d = v_last ? '0 : vcnt_q + 1'b1;
            end else begin
                hcnt_d = hcnt_q + 1'b1;
            end
        end
    end

    // Counter registers; reset wins over pix_en and abandons the current line.
    always_ff @(posedge clk) begin
        if (rst) begin
            hcnt_q <= '0;
            vcnt_q <= '0;
        end else begin
            hcnt_q <= hcnt_d;
            vcnt_q <= vcnt_d;
        end
    end

    // Sync, blanking and coordinate decode straight from the counters.
    always_comb begin
        h_active = (hcnt_q >= H_ACT_START_C) && ({1'b0, hcnt_q} < H_ACT_END_C);
        v_active = (vcnt_q >= V_ACT_START_C) && ({1'b0, vcnt_q} < V_ACT_END_C);
        active   = h_active && v_active;
        hsync_n  = !(hcnt_q < HSYN_C);
        vsync_n  = !(vcnt_q < VSYN_C);
        blank_n  = active;
        // Coordinates are zeroed outside the active area so consumers never
        // see the wrapped result of subtracting the porch offset.
        x        = active ? (hcnt_q - H_ACT_START_C) : '0;
        y        = active ? (vcnt_q - V_ACT_START_C) : '0;
    end

    // Strobes are level decodes of the counters and stay high while the
    // counters hold, so downstream logic must qualify them with pix_en.
    always_comb begin
        line_end    = h_last;
        frame_start = (hcnt_q == '0) && (vcnt_q == '0);
    end

    assign hcnt = hcnt_q;
    assign vcnt = vcnt_q;

`ifdef VGA_FRAME_CNT_EN
    logic [7:0] frame_cnt_q, frame_cnt_d;
    logic       frame_wrap;

    assign frame_wrap = pix_en && h_last && v_last;

    // Frame counter next value: bump on the edge that wraps both counters.
    always_comb begin
        frame_cnt_d = frame_cnt_q;
        if (frame_wrap) begin
            frame_cnt_d = frame_cnt_q + 8'd1;
        end
    end

    // Frame counter register, cleared by reset like the pixel counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            frame_cnt_q <= 8'd0;
        end else begin
            frame_cnt_q <= frame_cnt_d;
        end
    end

    assign frame_cnt = frame_cnt_q;
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench for vga_timing_gen. A full-size instance covers reset, line
// timing, active-area decode, enable gating and mid-frame reset; a shrunken
// instance covers the frame wrap within a short run.
module tb_vga_timing_gen;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Full-size instance
    logic       rst, pix_en;
    logic [9:0] hcnt, vcnt, x, y;
    logic       hsync_n, vsync_n, blank_n, line_end, frame_start;
`ifdef VGA_FRAME_CNT_EN
    logic [7:0] frame_cnt;
`endif

    vga_timing_gen u_dut (
        .clk         (clk),
        .rst         (rst),
        .pix_en      (pix_en),
`ifdef VGA_FRAME_CNT_EN
        .frame_cnt   (frame_cnt),
`endif
        .hcnt        (hcnt),
        .vcnt        (vcnt),
        .hsync_n     (hsync_n),
        .vsync_n     (vsync_n),
        .blank_n     (blank_n),
        .x           (x),
        .y           (y),
        .line_end    (line_end),
        .frame_start (frame_start)
    );

    // Small instance: HMAX = 2+2+4+2 = 10, VMAX = 1+1+3+1 = 6
    logic       rst_s, pix_en_s;
    logic [3:0] hcnt_s, vcnt_s, x_s, y_s;
    logic       hsync_n_s, vsync_n_s, blank_n_s, line_end_s, frame_start_s;
`ifdef VGA_FRAME_CNT_EN
    logic [7:0] frame_cnt_s;
`endif

    vga_timing_gen #(
        .N(4), .HSYN(2), .HBP(2), .HACTIVE(4), .HFP(2),
        .VSYN(1), .VBP(1), .VACTIVE(3), .VFP(1)
    ) u_small (
        .clk         (clk),
        .rst         (rst_s),
        .pix_en      (pix_en_s),
`ifdef VGA_FRAME_CNT_EN
        .frame_cnt   (frame_cnt_s),
`endif
        .hcnt        (hcnt_s),
        .vcnt        (vcnt_s),
        .hsync_n     (hsync_n_s),
        .vsync_n     (vsync_n_s),
        .blank_n     (blank_n_s),
        .x           (x_s),
        .y           (y_s),
        .line_end    (line_end_s),
        .frame_start (frame_start_s)
    );

    int checks   = 0;
    int failures = 0;
    logic blank_seen;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // One clock; inputs change and outputs are sampled 1 time unit after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
        if (blank_n !== 1'b0) blank_seen = 1'b1;
    endtask

    task automatic adv(input int n);
        repeat (n) tick();
    endtask

    initial begin
        int exph, expv, vs_low;
        rst = 1'b1; pix_en = 1'b0;
        rst_s = 1'b1; pix_en_s = 1'b0;
        blank_seen = 1'b0;

        // Reset state
        tick();
        rst = 1'b0;
        chk("rst_hcnt", 32'(hcnt), 0);
        chk("rst_vcnt", 32'(vcnt), 0);
        chk("rst_hsync_n", 32'(hsync_n), 0);
        chk("rst_vsync_n", 32'(vsync_n), 0);
        chk("rst_blank_n", 32'(blank_n), 0);
        chk("rst_x", 32'(x), 0);
        chk("rst_y", 32'(y), 0);
        chk("rst_line_end", 32'(line_end), 0);
        chk("rst_frame_start", 32'(frame_start), 1);

        // Line 0: hsync low for 0..95, high from 96, no active pixels
        blank_seen = 1'b0;
        pix_en = 1'b1;
        tick();
        chk("h1_hcnt", 32'(hcnt), 1);
        chk("h1_frame_start", 32'(frame_start), 0);
        adv(94);
        chk("h95_hcnt", 32'(hcnt), 95);
        chk("h95_hsync_n", 32'(hsync_n), 0);
        tick();
        chk("h96_hsync_n", 32'(hsync_n), 1);
        adv(703);
        chk("h799_hcnt", 32'(hcnt), 799);
        chk("h799_vcnt", 32'(vcnt), 0);
        chk("h799_line_end", 32'(line_end), 1);
        chk("line0_no_blank", 32'(blank_seen), 0);

        // Line wrap
        tick();
        chk("wrap_hcnt", 32'(hcnt), 0);
        chk("wrap_vcnt", 32'(vcnt), 1);
        chk("wrap_line_end", 32'(line_end), 0);
        chk("v1_vsync_n", 32'(vsync_n), 0);
        adv(800);
        chk("v2_vcnt", 32'(vcnt), 2);
        chk("v2_vsync_n", 32'(vsync_n), 1);

        // Active area edges on line 35
        adv(33 * 800 + 143);
        chk("v35h143_hcnt", 32'(hcnt), 143);
        chk("v35h143_vcnt", 32'(vcnt), 35);
        chk("v35h143_blank_n", 32'(blank_n), 0);
        chk("v35h143_x", 32'(x), 0);
        tick();
        chk("v35h144_blank_n", 32'(blank_n), 1);
        chk("v35h144_x", 32'(x), 0);
        chk("v35h144_y", 32'(y), 0);
        adv(639);
        chk("h783_blank_n", 32'(blank_n), 1);
        chk("h783_x", 32'(x), 639);
        tick();
        chk("h784_blank_n", 32'(blank_n), 0);
        chk("h784_x", 32'(x), 0);

        // Counters hold while pix_en is low
        pix_en = 1'b0;
        adv(3);
        chk("hold_hcnt", 32'(hcnt), 784);
        chk("hold_vcnt", 32'(vcnt), 35);

        // Mid-frame reset with pix_en high
        pix_en = 1'b1;
        adv(16 + 400);
        chk("pre_rst_hcnt", 32'(hcnt), 400);
        chk("pre_rst_vcnt", 32'(vcnt), 36);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("mid_rst_hcnt", 32'(hcnt), 0);
        chk("mid_rst_vcnt", 32'(vcnt), 0);
        chk("mid_rst_frame_start", 32'(frame_start), 1);
`ifdef VGA_FRAME_CNT_EN
        chk("mid_rst_frame_cnt", 32'(frame_cnt), 0);
`endif

        // pix_en one clock in two: a line takes 1600 clocks
        exph = 0;
        expv = 0;
        for (int i = 0; i < 1600; i++) begin
            pix_en = (i % 2 == 0);
            tick();
            if (i % 2 == 0) begin
                if (exph == 799) begin
                    exph = 0;
                    expv = expv + 1;
                end else begin
                    exph = exph + 1;
                end
            end
            chk("half_rate_hcnt", 32'(hcnt), 32'(exph));
            if (exph == 799) chk("half_rate_line_end", 32'(line_end), 1);
        end
        chk("half_rate_end_hcnt", 32'(hcnt), 0);
        chk("half_rate_end_vcnt", 32'(vcnt), 1);
        pix_en = 1'b0;

        // Small instance: full frame of 60 pixels
        rst_s = 1'b0;
        pix_en_s = 1'b1;
        vs_low = (vsync_n_s == 1'b0) ? 1 : 0;
        for (int t = 1; t <= 60; t++) begin
            tick();
            if (t < 60 && vsync_n_s == 1'b0) vs_low++;
            if (t == 22) begin
                chk("s_t22_hsync_n", 32'(hsync_n_s), 1);
                chk("s_t22_blank_n", 32'(blank_n_s), 0);
            end
            if (t == 47) begin
                chk("s_t47_blank_n", 32'(blank_n_s), 1);
                chk("s_t47_x", 32'(x_s), 3);
                chk("s_t47_y", 32'(y_s), 2);
            end
            if (t == 48) begin
                chk("s_t48_blank_n", 32'(blank_n_s), 0);
                chk("s_t48_x", 32'(x_s), 0);
            end
            if (t == 59) begin
                chk("s_t59_hcnt", 32'(hcnt_s), 9);
                chk("s_t59_vcnt", 32'(vcnt_s), 5);
                chk("s_t59_line_end", 32'(line_end_s), 1);
                chk("s_t59_frame_start", 32'(frame_start_s), 0);
            end
        end
        chk("s_wrap_hcnt", 32'(hcnt_s), 0);
        chk("s_wrap_vcnt", 32'(vcnt_s), 0);
        chk("s_wrap_frame_start", 32'(frame_start_s), 1);
        chk("s_vsync_low_clocks", 32'(vs_low), 10);
`ifdef VGA_FRAME_CNT_EN
        chk("s_frame_cnt", 32'(frame_cnt_s), 1);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
